pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the fetch stage. Successor to the single-width PC register.
- Generalises address width, reset and trap vectors, and instruction alignment.
- Adds fetch back-pressure, pipeline stall, absolute/JALR redirects, trap entry, misaligned-target detection, and a circular return-address stack (RAS) for return prediction.
- Sits between branch/jump resolution (execute stage) and the instruction-memory port.

Parameters:
- XLEN, 32: address/data width of PC and targets.
- RESET_VEC, 0: PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100: PC loaded on trap or misaligned redirect.
- ALIGN_BITS, 2: number of PC LSBs that must be zero (2 gives 4-byte instructions).
- RAS_DEPTH, 4: RAS entries, power of two, minimum 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- fetch_ready  in  1  imem accepts the current pc this cycle
- stall  in  1  downstream stall; hold PC
- redir_valid  in  1  redirect request from execute
- redir_base  in  XLEN  redirect base (branch PC or rs1)
- redir_off  in  XLEN  signed offset, two's complement
- redir_jalr  in  1  clear bit 0 of the computed target
- trap_valid  in  1  trap request
- ras_push  in  1  push ras_push_addr (call)
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  pop (return)
- pc  out  XLEN  current fetch address
- pc_valid  out  1  pc is a valid fetch request
- flush  out  1  registered one-cycle pulse: pc holds a redirect/trap target
- misalign  out  1  registered one-cycle pulse: last redirect target was misaligned
- ras_top  out  XLEN  predicted return address (top entry)
- ras_empty  out  1  RAS count == 0

Behaviour:
- Reset (rst_n low, async): pc=RESET_VEC, pc_valid=0, flush=0, misalign=0, RAS count=0, RAS pointer=0, ras_empty=1, ras_top=0 (all entries cleared).
- pc_valid rises on the first clk edge after rst_n deasserts and stays 1 thereafter.
- Redirect target: tgt = (redir_base + redir_off) mod 2^XLEN; if redir_jalr, tgt[0]=0. Misaligned when tgt[ALIGN_BITS-1:0] != 0 after the JALR clear.
- Next-PC priority, evaluated each edge:
  1. trap_valid: pc=TRAP_VEC, flush=1.
  2. redir_valid with misaligned tgt: pc=TRAP_VEC, flush=1, misalign=1.
  3. redir_valid with aligned tgt: pc=tgt, flush=1.
  4. stall, or !fetch_ready, or !pc_valid: pc holds.
  5. Otherwise: pc = pc + 2^ALIGN_BITS, wrapping mod 2^XLEN.
- Trap and redirect override stall and fetch_ready. The same-cycle fetch is discarded by the consumer via flush.
- flush and misalign are registered: high exactly in the cycle after the request edge, i.e. while pc shows the new target. Low otherwise.
- Back-to-back redirects: each produces its own flush cycle; the last one wins.
- RAS is a circular buffer with pointer ptr and saturating count (0..RAS_DEPTH):
  - push only: entry[ptr]=addr; ptr++ (wraps); count=min(count+1, RAS_DEPTH). On overflow the oldest entry is overwritten silently.
  - pop only: if count>0 then ptr--, count--. Pop on empty is ignored.
  - push and pop together: entry[ptr-1]=addr (replace top); ptr and count unchanged. If empty, treat as push only.
  - ras_top = entry[ptr-1], combinational from state; 0 when empty.
- RAS is not cleared by flush or trap, only by reset.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of clk.

Test Plan:
- Reset and run: rst_n low then released, fetch_ready=1 -> pc=0 with pc_valid=0 in cycle 0, then pc 0,4,8,12 with pc_valid=1.
- Stall and back-pressure: at pc=8, stall=1 for 3 cycles, then fetch_ready=0 for 2 cycles -> pc stays 8 for 5 cycles, then 12.
- Redirect and JALR: redir base=0x100, off=-8 -> pc=0xF8, flush pulse 1 cycle. JALR base=0x201, off=0x3, jalr=1 -> target 0x204 (bit 0 cleared, aligned), pc=0x204, misalign=0.
- Misaligned redirect and priority: base=0x100, off=2 -> pc=0x100 (TRAP_VEC), misalign=1 and flush=1 for 1 cycle. trap_valid and redir_valid together with stall=1 -> pc=TRAP_VEC.
- RAS with DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 -> ras_top=0x50. Four pops -> tops 0x40,0x30,0x20, then ras_empty=1. A fifth pop is ignored. Push with pop on non-empty replaces top with count unchanged.
- Wrap and async reset: pc=0xFFFF_FFFC advance -> 0x0. Assert rst_n mid-cycle -> pc=RESET_VEC and ras_empty=1 before the next clk edge.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect/trap steering, misaligned-target
// detection and a circular return-address stack for return prediction.
module pc_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int              ALIGN_BITS = 2,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_off,
    input  logic            redir_jalr,
    input  logic            trap_valid,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty
);

    localparam int              PTR_W      = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam int              CNT_W      = PTR_W + 1;
    localparam logic [XLEN-1:0] PC_INC     = XLEN'(1) << ALIGN_BITS;
    localparam logic [XLEN-1:0] ALIGN_MASK = PC_INC - XLEN'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
    endfunction

    logic signed [XLEN-1:0] redir_off_s;
    logic [XLEN-1:0]        tgt_sum_p0;
    logic [XLEN-1:0]        tgt_p0;
    logic                   tgt_mis_p0;
    logic [XLEN-1:0]        pc_nxt_p0;
    logic                   flush_nxt_p0;
    logic                   mis_nxt_p0;

    logic [XLEN-1:0]        pc_p1;
    logic                   vld_p1;
    logic                   flush_p1;
    logic                   mis_p1;

    logic [XLEN-1:0]        ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]       ras_ptr;
    logic [PTR_W-1:0]       ras_ptr_m1;
    logic [CNT_W-1:0]       ras_cnt;

    // Stage p0: redirect target and next-PC selection
    assign redir_off_s = redir_off;
    assign tgt_sum_p0  = redir_base + $unsigned(redir_off_s);
    assign tgt_p0      = redir_jalr ? {tgt_sum_p0[XLEN-1:1], 1'b0} : tgt_sum_p0;
    assign tgt_mis_p0  = |(tgt_p0 & ALIGN_MASK);

    always_comb begin
        pc_nxt_p0    = pc_p1;
        flush_nxt_p0 = 1'b0;
        mis_nxt_p0   = 1'b0;
        if (trap_valid) begin
            pc_nxt_p0    = TRAP_VEC;
            flush_nxt_p0 = 1'b1;
        end else if (redir_valid && tgt_mis_p0) begin
            pc_nxt_p0    = TRAP_VEC;
            flush_nxt_p0 = 1'b1;
            mis_nxt_p0   = 1'b1;
        end else if (redir_valid) begin
            pc_nxt_p0    = tgt_p0;
            flush_nxt_p0 = 1'b1;
        end else if (!stall && fetch_ready && vld_p1) begin
            pc_nxt_p0    = pc_p1 + PC_INC;
        end
    end

    // Stage p1: architectural PC and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_p1    <= RESET_VEC;
            vld_p1   <= 1'b0;
            flush_p1 <= 1'b0;
            mis_p1   <= 1'b0;
        end else begin
            pc_p1    <= pc_nxt_p0;
            vld_p1   <= 1'b1;
            flush_p1 <= flush_nxt_p0;
            mis_p1   <= mis_nxt_p0;
        end
    end

    assign pc       = pc_p1;
    assign pc_valid = vld_p1;
    assign flush    = flush_p1;
    assign misalign = mis_p1;

    // Return-address stack; push+pop on a non-empty stack rewrites the top in place
    assign ras_ptr_m1 = ras_ptr - PTR_W'(1);
    assign ras_empty  = (ras_cnt == '0);
    assign ras_top    = ras_empty ? '0 : ras_mem[ras_ptr_m1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push && (!ras_pop || ras_empty)) begin
            ras_mem[ras_ptr] <= ras_push_addr;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            ras_cnt          <= sat_inc(ras_cnt);
        end else if (ras_push && ras_pop) begin
            ras_mem[ras_ptr_m1] <= ras_push_addr;
        end else if (ras_pop && !ras_empty) begin
            ras_ptr <= ras_ptr_m1;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: run, stall, redirects, traps, RAS and async reset.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_base;
    logic [31:0] redir_off;
    logic        redir_jalr;
    logic        trap_valid;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign;
    logic [31:0] ras_top;
    logic        ras_empty;

    int n_cmp = 0;
    int n_err = 0;

    pc_unit #(
        .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h0000_0100),
        .ALIGN_BITS(2), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready), .stall(stall),
        .redir_valid(redir_valid), .redir_base(redir_base), .redir_off(redir_off),
        .redir_jalr(redir_jalr), .trap_valid(trap_valid), .ras_push(ras_push),
        .ras_push_addr(ras_push_addr), .ras_pop(ras_pop), .pc(pc),
        .pc_valid(pc_valid), .flush(flush), .misalign(misalign),
        .ras_top(ras_top), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] base, input logic [31:0] off, input logic jalr);
        redir_valid = 1'b1;
        redir_base  = base;
        redir_off   = off;
        redir_jalr  = jalr;
    endtask

    task automatic redir_clr();
        redir_valid = 1'b0;
        redir_jalr  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ready = 1'b1; stall = 1'b0; trap_valid = 1'b0;
        redir_valid = 1'b0; redir_base = '0; redir_off = '0; redir_jalr = 1'b0;
        ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;

        tick(); tick();
        chk_val("rst_pc", pc, 32'h0);
        chk_val("rst_vld", {31'b0, pc_valid}, 32'h0);
        chk_val("rst_flush", {31'b0, flush}, 32'h0);
        chk_val("rst_mis", {31'b0, misalign}, 32'h0);
        chk_val("rst_empty", {31'b0, ras_empty}, 32'h1);
        chk_val("rst_top", ras_top, 32'h0);

        rst_n = 1'b1;
        #1;
        chk_val("c0_pc", pc, 32'h0);
        chk_val("c0_vld", {31'b0, pc_valid}, 32'h0);
        tick();
        chk_val("run0_pc", pc, 32'h0);
        chk_val("run0_vld", {31'b0, pc_valid}, 32'h1);
        tick(); chk_val("run4_pc", pc, 32'h4);
        tick(); chk_val("run8_pc", pc, 32'h8);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_val("stall_pc", pc, 32'h8);
        end
        stall = 1'b0; fetch_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); chk_val("bp_pc", pc, 32'h8);
        end
        fetch_ready = 1'b1;
        tick(); chk_val("resume_pc", pc, 32'hC);

        redir(32'h100, 32'hFFFF_FFF8, 1'b0);
        tick();
        chk_val("br_pc", pc, 32'hF8);
        chk_val("br_flush", {31'b0, flush}, 32'h1);
        chk_val("br_mis", {31'b0, misalign}, 32'h0);
        redir_clr();
        tick();
        chk_val("br_next_pc", pc, 32'hFC);
        chk_val("br_flush_end", {31'b0, flush}, 32'h0);

        redir(32'h201, 32'h3, 1'b1);
        tick();
        chk_val("jalr1_pc", pc, 32'h204);
        chk_val("jalr1_flush", {31'b0, flush}, 32'h1);
        chk_val("jalr1_mis", {31'b0, misalign}, 32'h0);
        redir(32'h303, 32'h2, 1'b1);
        tick();
        chk_val("jalr2_pc", pc, 32'h304);
        chk_val("jalr2_flush", {31'b0, flush}, 32'h1);
        chk_val("jalr2_mis", {31'b0, misalign}, 32'h0);
        redir_clr();
        tick();
        chk_val("jalr_next_pc", pc, 32'h308);
        chk_val("jalr_flush_end", {31'b0, flush}, 32'h0);

        redir(32'h100, 32'h2, 1'b0);
        tick();
        chk_val("mis_pc", pc, 32'h100);
        chk_val("mis_flag", {31'b0, misalign}, 32'h1);
        chk_val("mis_flush", {31'b0, flush}, 32'h1);
        redir_clr();
        tick();
        chk_val("mis_next_pc", pc, 32'h104);
        chk_val("mis_flag_end", {31'b0, misalign}, 32'h0);
        chk_val("mis_flush_end", {31'b0, flush}, 32'h0);

        stall = 1'b1; trap_valid = 1'b1;
        redir(32'h400, 32'h0, 1'b0);
        tick();
        chk_val("prio_pc", pc, 32'h100);
        chk_val("prio_flush", {31'b0, flush}, 32'h1);
        chk_val("prio_mis", {31'b0, misalign}, 32'h0);
        trap_valid = 1'b0;
        redir(32'h500, 32'h0, 1'b0);
        tick();
        chk_val("stall_redir_pc", pc, 32'h500);
        redir_clr();
        tick();
        chk_val("stall_hold_pc", pc, 32'h500);
        chk_val("stall_flush_end", {31'b0, flush}, 32'h0);
        stall = 1'b0;

        ras_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ras_push_addr = 32'(i * 16);
            tick();
            chk_val("ras_push_top", ras_top, 32'(i * 16));
        end
        ras_push = 1'b0;
        chk_val("ras_full_empty", {31'b0, ras_empty}, 32'h0);
        ras_pop = 1'b1;
        tick(); chk_val("ras_pop1", ras_top, 32'h40);
        tick(); chk_val("ras_pop2", ras_top, 32'h30);
        tick(); chk_val("ras_pop3", ras_top, 32'h20);
        tick();
        chk_val("ras_pop4_empty", {31'b0, ras_empty}, 32'h1);
        chk_val("ras_pop4_top", ras_top, 32'h0);
        tick();
        chk_val("ras_pop5_empty", {31'b0, ras_empty}, 32'h1);
        ras_pop = 1'b0;

        ras_push = 1'b1; ras_push_addr = 32'h60;
        tick(); chk_val("ras_push60", ras_top, 32'h60);
        ras_pop = 1'b1; ras_push_addr = 32'h70;
        tick();
        chk_val("ras_repl_top", ras_top, 32'h70);
        ras_push = 1'b0;
        tick();
        chk_val("ras_repl_cnt", {31'b0, ras_empty}, 32'h1);
        ras_push = 1'b1; ras_push_addr = 32'h80;
        tick();
        chk_val("ras_pp_empty_top", ras_top, 32'h80);
        chk_val("ras_pp_empty_flag", {31'b0, ras_empty}, 32'h0);
        ras_push = 1'b0;
        tick();
        chk_val("ras_pp_pop", {31'b0, ras_empty}, 32'h1);
        ras_pop = 1'b0;

        ras_push = 1'b1; ras_push_addr = 32'h90;
        tick();
        ras_push = 1'b0; trap_valid = 1'b1;
        tick();
        trap_valid = 1'b0;
        chk_val("trap_pc", pc, 32'h100);
        chk_val("ras_keep_trap", ras_top, 32'h90);

        redir(32'hFFFF_FFF0, 32'hC, 1'b0);
        tick();
        chk_val("wrap_hi_pc", pc, 32'hFFFF_FFFC);
        redir_clr();
        tick(); chk_val("wrap_pc", pc, 32'h0);
        tick(); chk_val("wrap_next_pc", pc, 32'h4);

        #2 rst_n = 1'b0;
        #1;
        chk_val("arst_pc", pc, 32'h0);
        chk_val("arst_vld", {31'b0, pc_valid}, 32'h0);
        chk_val("arst_empty", {31'b0, ras_empty}, 32'h1);
        chk_val("arst_top", ras_top, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
